// File: rtl/hw_event_reporter.sv
`default_nettype none
// ============================================================================
// Module      : hw_event_reporter
// Description : Queues fabric game events (slice hits) in a small FIFO.
//               Packs each event into a 32-bit word and hands it to NIOS
//               software over the to_sw_sig/to_hw_sig four-phase handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module hw_event_reporter #(
  parameter int DEPTH    = 8,    // FIFO entries, power of two, >= 2
  parameter int SCREEN_H = 480   // screen height for the y-axis flip
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     event_valid,
  input  logic [3:0]               event_obj,
  input  logic [9:0]               event_x,
  input  logic [9:0]               event_y,
  input  logic [1:0]               to_hw_sig,
  output logic [31:0]              to_sw_port,
  output logic [1:0]               to_sw_sig,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int               c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL     = (c_AW + 1)'(DEPTH);
  localparam logic [9:0]       c_SCREEN_H = 10'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_hw_meta;
  logic [1:0]        r_hw_sync;
  logic [23:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_AW:0]     r_count;
  logic              r_overflow;
  logic [31:0]       r_port;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [9:0]        w_ysw;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  // A load only happens from IDLE once software has released the previous word.
  assign w_pop   = (r_state == S_IDLE) && !w_empty && (r_hw_sync == 2'd0);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push  = event_valid && (!w_full || w_pop);
  assign w_drop  = event_valid && w_full && !w_pop;
  // Software y grows bottom-up; the subtraction wraps mod 1024 on purpose.
  assign w_ysw   = c_SCREEN_H - event_y;

  // Two-flop synchroniser for the software handshake level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hw_meta <= 2'd0;
      r_hw_sync <= 2'd0;
    end else begin
      r_hw_meta <= to_hw_sig;
      r_hw_sync <= r_hw_meta;
    end
  end

  // FIFO storage holds the packed low 24 bits; no reset needed on data.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {event_obj, w_ysw, event_x};
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop wins over the clear so no loss is ever hidden from software.
      if (w_drop)     r_overflow <= 1'b1;
      else if (w_pop) r_overflow <= 1'b0;
    end
  end

  // Output word register: loaded with the FIFO head plus the drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port <= 32'd0;
    end else if (w_pop) begin
      r_port <= {r_overflow, 7'd0, r_mem[r_rptr]};
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Handshake next-state: present, wait for ACK, wait for release.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pop)                w_next = S_PRESENT;
      S_PRESENT: if (r_hw_sync == 2'd1)    w_next = S_RELEASE;
      S_RELEASE: if (r_hw_sync == 2'd0)    w_next = S_IDLE;
      default:                             w_next = S_IDLE;
    endcase
  end

  assign to_sw_sig  = (r_state == S_PRESENT) ? 2'd1 : 2'd0;
  assign to_sw_port = r_port;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hw_event_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hw_event_reporter
// Description : Directed self-checking bench for hw_event_reporter; expected
//               words are queued at stimulus time and popped when presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hw_event_reporter;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        event_valid;
  logic [3:0]  event_obj;
  logic [9:0]  event_x;
  logic [9:0]  event_y;
  logic [1:0]  to_hw_sig;
  logic [31:0] to_sw_port;
  logic [1:0]  to_sw_sig;
  logic [3:0]  fifo_count;
  logic        overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb [$];
  logic [31:0] last_word = 32'd0;

  hw_event_reporter #(.DEPTH(DEPTH), .SCREEN_H(480)) dut (
    .clk         (clk),
    .reset       (reset),
    .event_valid (event_valid),
    .event_obj   (event_obj),
    .event_x     (event_x),
    .event_y     (event_y),
    .to_hw_sig   (to_hw_sig),
    .to_sw_port  (to_sw_port),
    .to_sw_sig   (to_sw_sig),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference packing, written from the word layout independently of the RTL.
  function automatic logic [31:0] pack(input int obj, input int x, input int y, input bit drop);
    int ysw;
    ysw = ((480 - y) % 1024 + 1024) % 1024;
    return {drop, 7'd0, obj[3:0], ysw[9:0], x[9:0]};
  endfunction

  // One-cycle event pulse; accepted events go to the scoreboard.
  task automatic send(input int obj, input int x, input int y, input bit accept, input bit drop);
    event_valid = 1'b1;
    event_obj   = obj[3:0];
    event_x     = x[9:0];
    event_y     = y[9:0];
    if (accept) sb.push_back(pack(obj, x, y, drop));
    @(negedge clk);
    event_valid = 1'b0;
  endtask

  task automatic wait_sig(input logic [1:0] v, input string tag);
    int k = 0;
    while (to_sw_sig !== v && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(to_sw_sig), 32'(v));
  endtask

  // Wait for a presented word and compare it to the scoreboard head.
  task automatic present_check(input string tag);
    logic [31:0] exp;
    wait_sig(2'd1, {tag, "_valid"});
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL %s_sb: observed word 0x%0h expected no word", tag, to_sw_port);
    end
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      last_word = exp;
      check({tag, "_word"}, to_sw_port, exp);
    end
  endtask

  // Software ACK then release; the word must hold through RELEASE.
  task automatic ack_release(input string tag);
    to_hw_sig = 2'd1;
    wait_sig(2'd0, {tag, "_ackdrop"});
    check({tag, "_hold"}, to_sw_port, last_word);
    to_hw_sig = 2'd0;
  endtask

  initial begin
    reset = 1'b1; event_valid = 1'b0; event_obj = '0; event_x = '0; event_y = '0;
    to_hw_sig = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_port", to_sw_port, 32'd0);
    check("rst_sig", 32'(to_sw_sig), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single event: latency, packing, ignored codes, full handshake.
    send(3, 100, 80, 1'b1, 1'b0);
    check("t1_count_push", 32'(fifo_count), 32'd1);
    check("t1_sig_preload", 32'(to_sw_sig), 32'd0);
    @(negedge clk);
    check("t1_sig_load", 32'(to_sw_sig), 32'd1);
    check("t1_port_const", to_sw_port, 32'h0036_4064);
    check("t1_count_load", 32'(fifo_count), 32'd0);
    present_check("t1");
    to_hw_sig = 2'd2;
    repeat (5) @(negedge clk);
    check("t1_ignore2", 32'(to_sw_sig), 32'd1);
    to_hw_sig = 2'd3;
    repeat (5) @(negedge clk);
    check("t1_ignore3", 32'(to_sw_sig), 32'd1);
    ack_release("t1");
    repeat (6) @(negedge clk);
    check("t1_idle_sig", 32'(to_sw_sig), 32'd0);
    check("t1_idle_count", 32'(fifo_count), 32'd0);

    // Three events while software is idle: ordering and occupancy.
    send(1, 10, 20, 1'b1, 1'b0);
    send(2, 30, 40, 1'b1, 1'b0);
    send(4, 50, 60, 1'b1, 1'b0);
    check("t2_count_wait", 32'(fifo_count), 32'd2);
    repeat (3) @(negedge clk);
    check("t2_count_hold", 32'(fifo_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      present_check("t2");
      ack_release("t2");
    end
    repeat (6) @(negedge clk);
    check("t2_count_end", 32'(fifo_count), 32'd0);

    // Overflow: DEPTH+3 events, the last two are dropped.
    for (int i = 0; i < DEPTH + 3; i++) begin
      send(i, i * 7 + 1, i * 11, (i <= DEPTH), (i == 1));
    end
    check("t3_count_sat", 32'(fifo_count), 32'(DEPTH));
    check("t3_ovf_set", 32'(overflow), 32'd1);
    present_check("t3_first");
    ack_release("t3_first");
    present_check("t3_flagged");
    check("t3_ovf_clear", 32'(overflow), 32'd0);
    ack_release("t3_flagged");
    for (int i = 2; i <= DEPTH; i++) begin
      present_check("t3_rest");
      ack_release("t3_rest");
    end
    repeat (6) @(negedge clk);
    check("t3_count_end", 32'(fifo_count), 32'd0);
    check("t3_ovf_end", 32'(overflow), 32'd0);

    // Push on the same edge as a pop while full: accepted, no overflow.
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(i + 2, 200 + i, 100 + i, 1'b1, 1'b0);
    end
    check("t4_full", 32'(fifo_count), 32'(DEPTH));
    present_check("t4_head");
    to_hw_sig = 2'd1;
    wait_sig(2'd0, "t4_release_state");
    to_hw_sig = 2'd0;
    // Release reaches IDLE three edges later; the pop is on the fourth.
    repeat (3) @(negedge clk);
    send(15, 999, 7, 1'b1, 1'b0);
    check("t4_count_stays", 32'(fifo_count), 32'(DEPTH));
    check("t4_no_ovf", 32'(overflow), 32'd0);
    check("t4_sig_loaded", 32'(to_sw_sig), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      present_check("t4_drain");
      ack_release("t4_drain");
    end
    repeat (6) @(negedge clk);
    check("t4_count_end", 32'(fifo_count), 32'd0);

    // y below the screen bottom wraps the flipped coordinate.
    send(5, 0, 500, 1'b1, 1'b0);
    present_check("t5");
    check("t5_yfield", 32'(to_sw_port[19:10]), 32'd1004);
    ack_release("t5");
    repeat (6) @(negedge clk);

    // Asynchronous reset while presenting with two words queued.
    send(6, 11, 12, 1'b1, 1'b0);
    send(7, 13, 14, 1'b1, 1'b0);
    send(8, 15, 16, 1'b1, 1'b0);
    present_check("t6_pre");
    check("t6_count_pre", 32'(fifo_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_sig", 32'(to_sw_sig), 32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_port", to_sw_port, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    to_hw_sig = 2'd1;
    repeat (4) @(negedge clk);
    to_hw_sig = 2'd0;
    repeat (8) @(negedge clk);
    check("t6_no_word", 32'(to_sw_sig), 32'd0);
    check("t6_count_zero", 32'(fifo_count), 32'd0);
    send(9, 321, 123, 1'b1, 1'b0);
    present_check("t6_new");
    ack_release("t6_new");
    repeat (6) @(negedge clk);
    check("t6_end_sig", 32'(to_sw_sig), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
